// File: rtl/score_banner_slider.sv
// Placement and slide animation for the "your score" banner.
// Registered hit test that feeds the bitmap stage, with a frame-synchronous position update.
module score_banner_slider #(
  parameter int OBJECT_WIDTH_X  = 80,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int START_X         = 640,
  parameter int TARGET_X        = 280,
  parameter int TOP_Y           = 100,
  parameter int STEP            = 8,
  parameter int HOLD_FRAMES     = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        show,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        busy
);

  // state     | meaning
  // IDLE      | parked at START_X, banner not drawn
  // SLIDE_IN  | moving left by STEP per frame toward TARGET_X
  // HOLD      | resting at TARGET_X for HOLD_FRAMES frames
  // SLIDE_OUT | moving right by STEP per frame toward START_X
  typedef enum logic [1:0] {IDLE, SLIDE_IN, HOLD, SLIDE_OUT} state_t;

  localparam logic [10:0] LP_START  = 11'(START_X);
  localparam logic [10:0] LP_TARGET = 11'(TARGET_X);
  localparam logic [10:0] LP_STEP   = 11'(STEP);
  localparam logic [7:0]  LP_HOLD   = 8'(HOLD_FRAMES);

  state_t      r_state, w_state_nxt;
  logic [10:0] r_topLeftX, w_topLeftX_nxt;
  logic [7:0]  r_holdCnt, w_holdCnt_nxt;
  logic [7:0]  w_hold_inc;
  logic [10:0] w_x_down, w_x_up;
  logic [11:0] w_sum_up, w_right;
  logic        w_inside;

  // Clamped steps land exactly on the endpoints for any STEP.
  assign w_sum_up   = {1'b0, r_topLeftX} + 12'(STEP);
  assign w_x_up     = (w_sum_up >= 12'(START_X)) ? LP_START : w_sum_up[10:0];
  assign w_x_down   = ({1'b0, r_topLeftX} >= (12'(TARGET_X) + 12'(STEP))) ?
                      (r_topLeftX - LP_STEP) : LP_TARGET;
  assign w_hold_inc = r_holdCnt + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_topLeftX_nxt = r_topLeftX;
    w_holdCnt_nxt  = r_holdCnt;
    case (r_state)
      IDLE: begin
        w_topLeftX_nxt = LP_START;
        if (show) w_state_nxt = SLIDE_IN;
      end
      SLIDE_IN: begin
        if (startOfFrame) begin
          w_topLeftX_nxt = w_x_down;
          if (w_x_down == LP_TARGET) begin
            w_state_nxt   = HOLD;
            w_holdCnt_nxt = 8'd0;
          end
        end
      end
      HOLD: begin
        if (show) begin
          w_holdCnt_nxt = 8'd0;
        end else if (startOfFrame) begin
          w_holdCnt_nxt = w_hold_inc;
          if (w_hold_inc == LP_HOLD) w_state_nxt = SLIDE_OUT;
        end
      end
      SLIDE_OUT: begin
        if (show) begin
          w_state_nxt = SLIDE_IN;
        end else if (startOfFrame) begin
          w_topLeftX_nxt = w_x_up;
          if (w_x_up == LP_START) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Right edge evaluated at 12 bits so a banner near 2047 cannot wrap.
  assign w_right  = {1'b0, r_topLeftX} + 12'(OBJECT_WIDTH_X);
  assign w_inside = (r_state != IDLE) &&
                    (pixelX >= r_topLeftX) && ({1'b0, pixelX} < w_right) &&
                    ({1'b0, pixelY} >= 12'(TOP_Y)) &&
                    ({1'b0, pixelY} < (12'(TOP_Y) + 12'(OBJECT_HEIGHT_Y)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_topLeftX      <= LP_START;
      r_holdCnt       <= 8'd0;
      InsideRectangle <= 1'b0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      busy            <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_topLeftX      <= w_topLeftX_nxt;
      r_holdCnt       <= w_holdCnt_nxt;
      InsideRectangle <= w_inside;
      offsetX         <= w_inside ? (pixelX - r_topLeftX) : 11'd0;
      offsetY         <= w_inside ? (pixelY - 11'(TOP_Y)) : 11'd0;
      busy            <= (w_state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_score_banner_slider.sv
// Directed bench for score_banner_slider: default instance plus a STEP=7 instance.
// Banner position is observed through the hit test at its left edge.
module tb_score_banner_slider;
  logic        clk = 1'b0;
  logic        reset, startOfFrame, show;
  logic [10:0] pixelX, pixelY;
  logic        ins_a, busy_a, ins_b, busy_b;
  logic [10:0] offx_a, offy_a, offx_b, offy_b;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_banner_slider dut_a (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .show(show),
    .pixelX(pixelX), .pixelY(pixelY), .InsideRectangle(ins_a),
    .offsetX(offx_a), .offsetY(offy_a), .busy(busy_a));

  score_banner_slider #(.STEP(7)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .show(show),
    .pixelX(pixelX), .pixelY(pixelY), .InsideRectangle(ins_b),
    .offsetX(offx_b), .offsetY(offy_b), .busy(busy_b));

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_show();
    show = 1'b1;
    tick();
    show = 1'b0;
  endtask

  task automatic probe(input int px, input int py);
    pixelX = 11'(px);
    pixelY = 11'(py);
    tick();
  endtask

  // Left edge at x: x is inside with offset 0, x-1 is outside.
  task automatic at_x(input string tag, input bit sel_b, input int x);
    probe(x, 100);
    check({tag, "_in"}, sel_b ? int'(ins_b) : int'(ins_a), 1);
    check({tag, "_offx"}, sel_b ? int'(offx_b) : int'(offx_a), 0);
    probe(x - 1, 100);
    check({tag, "_left"}, sel_b ? int'(ins_b) : int'(ins_a), 0);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; show = 1'b0;
    pixelX = 11'd280; pixelY = 11'd100;
    tick(); tick();
    check("rst_inside", int'(ins_a), 0);
    check("rst_offx", int'(offx_a), 0);
    check("rst_offy", int'(offy_a), 0);
    check("rst_busy", int'(busy_a), 0);
    reset = 1'b0;

    for (int y = 0; y < 525; y += 35)
      for (int x = 0; x < 800; x += 50) begin
        probe(x, y);
        check("idle_inside", int'(ins_a), 0);
        check("idle_offs", int'({offx_a, offy_a}), 0);
      end
    probe(300, 110);
    check("idle_banner_area", int'(ins_a), 0);
    check("idle_busy", int'(busy_a), 0);

    // Slide in
    pulse_show();
    check("show_busy", int'(busy_a), 1);
    at_x("slin0", 1'b0, 640);
    frames(1);
    at_x("slin1", 1'b0, 632);
    frames(43);
    at_x("slin44", 1'b0, 288);
    frames(1);
    at_x("slin45", 1'b0, 280);

    // Hit test at rest
    probe(280, 100);
    check("hit_tl_in", int'(ins_a), 1);
    check("hit_tl_offx", int'(offx_a), 0);
    check("hit_tl_offy", int'(offy_a), 0);
    probe(359, 119);
    check("hit_br_in", int'(ins_a), 1);
    check("hit_br_offx", int'(offx_a), 79);
    check("hit_br_offy", int'(offy_a), 19);
    probe(360, 119);
    check("hit_right_out", int'(ins_a), 0);
    check("hit_right_offx", int'(offx_a), 0);
    probe(280, 99);
    check("hit_above_out", int'(ins_a), 0);
    check("hit_above_offy", int'(offy_a), 0);
    probe(280, 120);
    check("hit_below_out", int'(ins_a), 0);

    // Hold then slide out
    frames(119);
    at_x("hold119", 1'b0, 280);
    frames(2);
    at_x("slout1", 1'b0, 288);
    frames(43);
    at_x("slout44", 1'b0, 632);
    check("slout44_busy", int'(busy_a), 1);
    frames(1);
    check("slout45_busy", int'(busy_a), 0);
    probe(640, 100);
    check("idle_again_inside", int'(ins_a), 0);

    // Retrigger during slide-out
    pulse_show();
    frames(45);
    at_x("re_hold", 1'b0, 280);
    frames(120 + 15);
    at_x("re_out400", 1'b0, 400);
    pulse_show();
    check("re_busy", int'(busy_a), 1);
    at_x("re_noj", 1'b0, 400);
    frames(14);
    at_x("re_in14", 1'b0, 288);
    frames(1);
    at_x("re_in15", 1'b0, 280);

    // show together with startOfFrame at holdCnt=119 restarts the hold
    frames(119);
    show = 1'b1; startOfFrame = 1'b1;
    tick();
    show = 1'b0; startOfFrame = 1'b0;
    tick();
    frames(119);
    at_x("ext119", 1'b0, 280);
    frames(1);
    at_x("ext120", 1'b0, 280);
    frames(1);
    at_x("ext_out1", 1'b0, 288);

    // STEP=7 instance and reset in HOLD
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_busy_b", int'(busy_b), 0);
    pulse_show();
    frames(51);
    at_x("s7_51", 1'b1, 283);
    frames(1);
    at_x("s7_52", 1'b1, 280);
    frames(1);
    at_x("s7_53", 1'b1, 280);

    pixelX = 11'd300; pixelY = 11'd110;
    tick();
    check("pre_rst_inside", int'(ins_a), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("hold_rst_inside", int'(ins_a), 0);
    check("hold_rst_offx", int'(offx_a), 0);
    check("hold_rst_offy", int'(offy_a), 0);
    check("hold_rst_busy", int'(busy_a), 0);
    tick();
    check("hold_rst_idle", int'(ins_a), 0);
    pulse_show();
    at_x("hold_rst_x640", 1'b0, 640);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
